hex_scan_display: RTL and testbench

//  Read side of the switch-loaded 8-bit register path: captures the register value on a load strobe
//  and shows it as 2 hex digits on a time-multiplexed, common-anode 7-segment display.

---
 rtl/hex_scan_display.sv | 88 ++++++++
 tb/tb_hex_scan_display.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Captures a register value on a load strobe and time-multiplexes it as hex digits
// onto a common-anode 7-segment display; every display output is registered.
module hex_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NDIG        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldp,
  input  logic [4*NDIG-1:0] qin,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [4*NDIG-1:0] disp_q;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic [NDIG-1:0]   an_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Digit select decoded from the current idx register
  always_comb begin
    nib    = '0;
    an_nxt = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        nib       = disp_q[4*i +: 4];
        an_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      cnt    <= '0;
      idx    <= '0;
      an     <= '1;
      seg    <= 7'h7F;
      tick   <= 1'b0;
      dp     <= 1'b1;
    end else begin
      if (ldp)
        disp_q <= qin;
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
      an  <= an_nxt;
      seg <= hex7(nib);
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: stimulus pushes model expectations per edge,
// a monitor pops and compares the registered outputs after each rising edge.
module tb_hex_scan_display;

  localparam int unsigned R = 4;
  localparam int unsigned N = 2;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst;
  logic       ldp;
  logic [7:0] qin;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       tick;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: value captured so far, and edges since reset release
  logic [7:0]  m_disp = '0;
  int unsigned mk     = 0;

  hex_scan_display #(.REFRESH_DIV(R), .NDIG(N)) dut (
    .clk (clk),
    .rst (rst),
    .ldp (ldp),
    .qin (qin),
    .an  (an),
    .seg (seg),
    .dp  (dp),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input logic r, input logic l, input logic [7:0] d);
    exp_t        e;
    int unsigned digit;
    @(negedge clk);
    rst = r;
    ldp = l;
    qin = d;
    if (r) begin
      e      = '{an: 2'b11, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
      m_disp = '0;
      mk     = 0;
    end else begin
      mk++;
      digit  = ((mk - 1) / R) % N;
      e.an   = ~(2'(1) << digit);
      e.seg  = HEX[(m_disp >> (4 * digit)) & 8'h0F];
      e.dp   = 1'b1;
      e.tick = (((mk - 1) % R) == R - 1);
      if (l)
        m_disp = d;
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("an",   8'(an),   8'(e.an));
        check("seg",  8'(seg),  8'(e.seg));
        check("dp",   8'(dp),   8'(e.dp));
        check("tick", 8'(tick), 8'(e.tick));
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    ldp = 1'b0;
    qin = '0;
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'hF0);
    step(1'b0, 1'b1, 8'hF0);
    repeat (12) step(1'b0, 1'b0, 8'hF0);
    step(1'b0, 1'b1, 8'h0F);
    repeat (10) step(1'b0, 1'b0, 8'hFF);
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, {4'(n), 4'(n)});
      repeat (8) step(1'b0, 1'b0, 8'(8'($urandom)));
    end
    // Reach digit 1 lit with the refresh counter at 2, then reset mid-scan
    for (int i = 0; i < 40 && !((mk % R) == 2 && ((mk / R) % N) == 1); i++)
      step(1'b0, 1'b0, 8'h5A);
    n_cmp++;
    if (!((mk % R) == 2 && ((mk / R) % N) == 1)) begin
      n_bad++;
      $display("FAIL reach_midscan: got k=%0d expected cnt=2 idx=1", mk);
    end
    step(1'b1, 1'b0, 8'hA5);
    repeat (10) step(1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
    @(posedge clk);
    #2;
    check("sb_drain", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
